// File: rtl/register_file_sb.sv
// WISC register file: bit-cell rows on OR-combined bitlines, two read ports with
// write-before-read bypass, one write port, and a pending-write scoreboard.

module register_file_sb_row #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rsel1,
    input  logic              rsel2,
    output logic [DATA_W-1:0] bl1,
    output logic [DATA_W-1:0] bl2
);
    logic [DATA_W-1:0] q;

    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (we) q <= wdata;
    end

    // An unselected row drives 0 so the bitlines can simply be OR-ed together.
    assign bl1 = rsel1 ? q : '0;
    assign bl2 = rsel2 ? q : '0;
endmodule

module register_file_sb #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 16,
    parameter int ZERO_R0  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(NUM_REGS)-1:0] SrcReg1,
    input  logic [$clog2(NUM_REGS)-1:0] SrcReg2,
    input  logic                        ReadEn1,
    input  logic                        ReadEn2,
    input  logic [$clog2(NUM_REGS)-1:0] DstReg,
    input  logic                        WriteReg,
    input  logic [DATA_W-1:0]           DstData,
    input  logic [$clog2(NUM_REGS)-1:0] IssueReg,
    input  logic                        IssueValid,
    output logic [DATA_W-1:0]           SrcData1,
    output logic [DATA_W-1:0]           SrcData2,
    output logic                        Busy1,
    output logic                        Busy2,
    output logic [NUM_REGS-1:0]         PendingMask
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic                             dst_r0, src1_r0, src2_r0;
    logic                             byp1, byp2;
    logic [NUM_REGS-1:0]              wen, rsel1, rsel2;
    logic [NUM_REGS-1:0][DATA_W-1:0]  bl1, bl2;
    logic [DATA_W-1:0]                rd1, rd2;
    logic [NUM_REGS-1:0]              pend_q, pend_d;

    assign dst_r0  = (ZERO_R0 != 0) && (DstReg  == '0);
    assign src1_r0 = (ZERO_R0 != 0) && (SrcReg1 == '0);
    assign src2_r0 = (ZERO_R0 != 0) && (SrcReg2 == '0);

    // One-hot row decode; a masked R0 never gets a row enable on any port.
    always_comb begin
        wen   = '0;
        rsel1 = '0;
        rsel2 = '0;
        if (WriteReg && !dst_r0) wen[DstReg]    = 1'b1;
        if (ReadEn1 && !src1_r0) rsel1[SrcReg1] = 1'b1;
        if (ReadEn2 && !src2_r0) rsel2[SrcReg2] = 1'b1;
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_row
        register_file_sb_row #(.DATA_W(DATA_W)) u_row (
            .clk   (clk),
            .rst   (rst),
            .we    (wen[r]),
            .wdata (DstData),
            .rsel1 (rsel1[r]),
            .rsel2 (rsel2[r]),
            .bl1   (bl1[r]),
            .bl2   (bl2[r])
        );
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd1 = rd1 | bl1[i];
            rd2 = rd2 | bl2[i];
        end
    end

    assign byp1 = WriteReg && ReadEn1 && (DstReg == SrcReg1) && !src1_r0;
    assign byp2 = WriteReg && ReadEn2 && (DstReg == SrcReg2) && !src2_r0;

    assign SrcData1 = byp1 ? DstData : rd1;
    assign SrcData2 = byp2 ? DstData : rd2;

    // Issue beats retire on the same register: a new producer replaces the old.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (IssueValid && IssueReg == IDX_W'(i))    pend_d[i] = 1'b1;
            else if (WriteReg && DstReg == IDX_W'(i))   pend_d[i] = 1'b0;
        end
        if (ZERO_R0 != 0) pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) pend_q <= '0;
        else     pend_q <= pend_d;
    end

    assign PendingMask = pend_q;

    assign Busy1 = ReadEn1 && pend_q[SrcReg1] && !(WriteReg && DstReg == SrcReg1);
    assign Busy2 = ReadEn2 && pend_q[SrcReg2] && !(WriteReg && DstReg == SrcReg2);
endmodule

// File: tb/tb_register_file_sb.sv
// Randomized + directed bench for register_file_sb against an array-based model.

module tb_register_file_sb;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  SrcReg1, SrcReg2, DstReg, IssueReg;
    logic        ReadEn1, ReadEn2, WriteReg, IssueValid;
    logic [15:0] DstData, SrcData1, SrcData2, PendingMask;
    logic        Busy1, Busy2;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] mregs[16];
    logic        mpend[16];

    always #5 clk = ~clk;

    register_file_sb #(.NUM_REGS(16), .DATA_W(16), .ZERO_R0(1)) dut (
        .clk(clk), .rst(rst),
        .SrcReg1(SrcReg1), .SrcReg2(SrcReg2), .ReadEn1(ReadEn1), .ReadEn2(ReadEn2),
        .DstReg(DstReg), .WriteReg(WriteReg), .DstData(DstData),
        .IssueReg(IssueReg), .IssueValid(IssueValid),
        .SrcData1(SrcData1), .SrcData2(SrcData2), .Busy1(Busy1), .Busy2(Busy2),
        .PendingMask(PendingMask)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] m_rd(input logic [3:0] s, input logic en);
        if (!en || s == 4'd0) return 16'h0;
        if (WriteReg && DstReg == s) return DstData;
        return mregs[s];
    endfunction

    function automatic logic m_busy(input logic [3:0] s, input logic en);
        return en && mpend[s] && !(WriteReg && DstReg == s);
    endfunction

    function automatic logic [15:0] m_mask();
        logic [15:0] m = '0;
        for (int i = 0; i < 16; i++) m[i] = mpend[i];
        return m;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 16; i++) begin
            mregs[i] = '0;
            mpend[i] = 1'b0;
        end
    endtask

    // One clock: check combinational outputs, advance model on the edge, check scoreboard.
    task automatic tick();
        #1;
        chk("rd1",   SrcData1, m_rd(SrcReg1, ReadEn1));
        chk("rd2",   SrcData2, m_rd(SrcReg2, ReadEn2));
        chk("busy1", Busy1,    m_busy(SrcReg1, ReadEn1));
        chk("busy2", Busy2,    m_busy(SrcReg2, ReadEn2));
        @(posedge clk);
        if (rst) m_clear();
        else begin
            if (WriteReg && DstReg != 4'd0) mregs[DstReg] = DstData;
            if (WriteReg)   mpend[DstReg]   = 1'b0;
            if (IssueValid) mpend[IssueReg] = 1'b1;
            mpend[0] = 1'b0;
        end
        #1;
        chk("mask", PendingMask, m_mask());
    endtask

    initial begin
        rst = 1'b1; SrcReg1 = 0; SrcReg2 = 0; ReadEn1 = 0; ReadEn2 = 0;
        DstReg = 0; WriteReg = 0; DstData = 0; IssueReg = 0; IssueValid = 0;
        @(posedge clk); #1;
        m_clear();

        // 1: reset then read
        rst = 1'b1; tick();
        rst = 1'b0; ReadEn1 = 1; ReadEn2 = 1; SrcReg1 = 3; SrcReg2 = 15;
        #1;
        chk("t1 rd1", SrcData1, 16'h0);
        chk("t1 rd2", SrcData2, 16'h0);
        chk("t1 mask", PendingMask, 16'h0);
        tick();

        // 2: write with same-cycle bypass, then stored read, then disabled read
        WriteReg = 1; DstReg = 5; DstData = 16'hBEEF; SrcReg1 = 5;
        #1; chk("t2 bypass", SrcData1, 16'hBEEF);
        tick();
        WriteReg = 0;
        #1; chk("t2 stored", SrcData1, 16'hBEEF);
        ReadEn1 = 0;
        #1; chk("t2 disabled", SrcData1, 16'h0);
        tick();

        // 3: R0 protection
        WriteReg = 1; DstReg = 0; DstData = 16'hFFFF; IssueValid = 1; IssueReg = 0;
        SrcReg1 = 0; ReadEn1 = 1;
        #1; chk("t3 r0 bypass", SrcData1, 16'h0);
        tick();
        WriteReg = 0; IssueValid = 0;
        #1;
        chk("t3 r0 rd", SrcData1, 16'h0);
        chk("t3 r0 pend", PendingMask[0], 1'b0);
        tick();

        // 4: scoreboard lifecycle
        IssueValid = 1; IssueReg = 7; tick();
        chk("t4 mask set", PendingMask, 16'h0080);
        IssueValid = 0; SrcReg2 = 7; ReadEn2 = 1;
        #1; chk("t4 busy", Busy2, 1'b1);
        WriteReg = 1; DstReg = 7; DstData = 16'h1357;
        #1;
        chk("t4 busy clr", Busy2, 1'b0);
        chk("t4 bypass", SrcData2, 16'h1357);
        tick();
        chk("t4 mask clr", PendingMask, 16'h0000);
        WriteReg = 0;

        // 5: simultaneous set/clear on reg 9
        IssueValid = 1; IssueReg = 9; tick();
        WriteReg = 1; DstReg = 9; DstData = 16'h1234; tick();
        chk("t5 pend9", PendingMask[9], 1'b1);
        WriteReg = 0; IssueValid = 0; SrcReg1 = 9; ReadEn1 = 1;
        #1; chk("t5 reg9", SrcData1, 16'h1234);
        tick();

        // 6: reset mid-operation
        WriteReg = 1; DstReg = 2; DstData = 16'hAAAA; IssueValid = 1; IssueReg = 2; tick();
        WriteReg = 0; IssueReg = 4; tick();
        IssueValid = 0;
        rst = 1; WriteReg = 1; DstReg = 4; DstData = 16'h5555; tick();
        chk("t6 mask", PendingMask, 16'h0000);
        rst = 0; WriteReg = 0; SrcReg1 = 2; SrcReg2 = 4; ReadEn1 = 1; ReadEn2 = 1;
        #1;
        chk("t6 reg2", SrcData1, 16'h0);
        chk("t6 reg4", SrcData2, 16'h0);
        tick();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rst        = ($urandom_range(0, 59) == 0);
            SrcReg1    = 4'($urandom_range(0, 15));
            SrcReg2    = ($urandom_range(0, 3) == 0) ? SrcReg1 : 4'($urandom_range(0, 15));
            ReadEn1    = ($urandom_range(0, 7) != 0);
            ReadEn2    = ($urandom_range(0, 7) != 0);
            WriteReg   = $urandom_range(0, 1) == 1;
            DstReg     = ($urandom_range(0, 2) == 0) ? SrcReg1 : 4'($urandom_range(0, 15));
            DstData    = 16'($urandom);
            IssueValid = ($urandom_range(0, 4) < 2);
            IssueReg   = ($urandom_range(0, 3) == 0) ? DstReg : 4'($urandom_range(0, 15));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- 16-entry x 16-bit register file for the WISC pipeline: two read ports, one write port.
- Storage is built from bit-cell rows. Each cell is a per-cell dff with write enable; a disabled read drives 0 onto its bitline.
- Adds write-before-read bypass and a pending-write scoreboard.
- Decode feeds it source and destination specifiers; writeback feeds it result data; hazard logic consumes its busy flags.

Parameters:
- NUM_REGS, 16, number of architectural registers (must be a power of 2).
- DATA_W, 16, register width in bits.
- ZERO_R0, 1, when 1 R0 reads as 0, writes to R0 are dropped and R0 is never marked busy.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- SrcReg1  input  4  read-port-1 register index.
- SrcReg2  input  4  read-port-2 register index.
- ReadEn1  input  1  read-port-1 enable; when 0 SrcData1 = 0.
- ReadEn2  input  1  read-port-2 enable; when 0 SrcData2 = 0.
- DstReg  input  4  writeback register index.
- WriteReg  input  1  writeback strobe.
- DstData  input  16  writeback data.
- IssueReg  input  4  destination of the instruction leaving decode.
- IssueValid  input  1  marks IssueReg pending.
- SrcData1  output  16  read-port-1 data (combinational).
- SrcData2  output  16  read-port-2 data (combinational).
- Busy1  output  1  SrcReg1 has an outstanding write (combinational).
- Busy2  output  1  SrcReg2 has an outstanding write (combinational).
- PendingMask  output  16  registered scoreboard state, bit i = register i pending.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - All registers and all PendingMask bits go to 0.
  - WriteReg and IssueValid are ignored that cycle.
  - Combinational read outputs then reflect zeroed storage: SrcData = 0, Busy = 0.
  - Reset mid-stream discards all pending marks; no writes complete afterwards.
- Write:
  - On the rising edge with WriteReg=1, reg[DstReg] <= DstData.
  - Exactly one row write-enable is asserted (one-hot decode of DstReg).
  - ZERO_R0=1 and DstReg=0: no row enabled.
- Read (zero-cycle latency):
  - SrcDataN = ReadEnN ? value : 0. Unselected rows drive 0, and rows are OR-combined, modelling the bitlines.
  - Bypass: if WriteReg=1, DstReg==SrcRegN, ReadEnN=1, and the register is not the masked R0, then SrcDataN = DstData in the same cycle.
  - Both ports may read the same register; both get identical data and bypass.
  - ZERO_R0=1 and SrcRegN=0: SrcDataN = 0 regardless of WriteReg.
- Scoreboard, per bit i at each rising edge:
  - set_i = IssueValid && IssueReg==i.
  - clr_i = WriteReg && DstReg==i.
  - Next bit = set_i ? 1 : (clr_i ? 0 : bit).
  - Set wins over clear: a new producer is issued while the old one retires.
  - ZERO_R0=1: bit 0 is held at 0.
- Busy flags:
  - BusyN = ReadEnN && PendingMask[SrcRegN] && !(WriteReg && DstReg==SrcRegN).
  - A same-cycle writeback clears the hazard combinationally, consistent with the bypass.
- Multiple writebacks to a non-pending register are legal; data updates and the bit stays 0.
- No X may propagate from unused state; all storage is reset.

Test Plan:
1. Reset then read: rst=1 for 1 cycle, then ReadEn1=ReadEn2=1, SrcReg1=3, SrcReg2=15 -> SrcData1=SrcData2=0x0000, Busy1=Busy2=0, PendingMask=0x0000.
2. Write then read with bypass:
   - Cycle 0: WriteReg=1, DstReg=5, DstData=0xBEEF, SrcReg1=5 -> SrcData1=0xBEEF in cycle 0.
   - Cycle 1: WriteReg=0 -> SrcData1 still 0xBEEF.
   - ReadEn1=0 -> SrcData1=0x0000.
3. R0 protection: WriteReg=1, DstReg=0, DstData=0xFFFF; IssueValid=1, IssueReg=0; next cycle SrcReg1=0 -> SrcData1=0x0000, PendingMask[0]=0.
4. Scoreboard lifecycle:
   - IssueValid=1, IssueReg=7 -> PendingMask=0x0080.
   - Next cycle SrcReg2=7, ReadEn2=1 -> Busy2=1.
   - WriteReg=1, DstReg=7 same cycle -> Busy2=0, SrcData2=DstData; next edge PendingMask=0x0000.
5. Simultaneous set/clear: reg 9 pending, IssueValid=1, IssueReg=9, WriteReg=1, DstReg=9, DstData=0x1234 -> after edge PendingMask[9]=1, reg9=0x1234.
6. Reset mid-operation: regs 2 and 4 pending, reg2=0xAAAA; assert rst with WriteReg=1, DstReg=4 -> after edge PendingMask=0x0000, reg2=0, reg4=0.
